edac_search_pipe: RTL and testbench
===================================

EDAC_SEARCH_PIPE -- requirements
Module: edac_search_pipe

Interface
- REQ-001 The block SHALL take parameter DW, default 32, data width in bits, legal 8..64.
- REQ-002 The block SHALL take parameter CRC_POLY, default 8'h97, CRC-8 polynomial (x^8 implicit).
- REQ-003 The block SHALL take parameter ERROR_CODE, default all-ones DW bits, output data on uncorrectable word.
- REQ-004 Port CLK, input, 1, system clock; all state changes on the rising edge.
- REQ-005 Port reset, input, 1, asynchronous active-low reset.
- REQ-006 Port en, input, 1, clock enable; low freezes all state and outputs.
- REQ-007 Port READ, input, 1, mode captured with the word: 1 decode/correct, 0 encode.
- REQ-008 Port in_valid / in_ready, input / output, 1 each, input handshake.
- REQ-009 Port in_data, input, DW; port in_crc, input, 8 (ignored when READ=0).
- REQ-010 Port out_valid / out_ready, output / input, 1 each, output handshake.
- REQ-011 Port out_data, output, DW; port out_crc, output, 8.
- REQ-012 Port corrected, output, 1, single-bit error repaired; port uncorrectable, output, 1, no correction found.

Function
- REQ-013 CRC SHALL be CRC-8 over data, MSB first, init 0, no reflection, no final XOR; codeword = {data, crc}, codeword bit j=0 is crc[0], j=8 is data[0].
- REQ-014 FSM states SHALL be IDLE, CHECK, SEARCH, DONE; in_ready SHALL be 1 only in IDLE.
- REQ-015 Transfer SHALL occur when in_valid and in_ready are high with en=1; word and READ are registered, FSM goes to CHECK.
- REQ-016 In CHECK, encode mode SHALL load out_data=data, out_crc=CRC(data), flags 0, and go to DONE.
- REQ-017 In CHECK, decode mode SHALL compute syndrome S = CRC(data) XOR crc; S=0 loads word unchanged, flags 0, goes to DONE; S!=0 sets j=0, probe P=8'h01, goes to SEARCH.
- REQ-018 In SEARCH, each cycle SHALL compare P with S; on match flip codeword bit j, load result, set corrected=1, go to DONE.
- REQ-019 On mismatch, SEARCH SHALL advance j by 1 and P = (P<<1) XOR (P[7] ? CRC_POLY : 0), truncated to 8 bits.
- REQ-020 Mismatch at j=DW+7 SHALL load out_data=ERROR_CODE, out_crc=8'hFF, uncorrectable=1, go to DONE.
- REQ-021 In DONE, out_valid SHALL be 1 and outputs SHALL hold stable until out_ready=1, then FSM returns to IDLE.
- REQ-022 Latency from accept edge to first out_valid cycle: clean or encode 2 cycles; correction at bit j: j+3 cycles; uncorrectable: DW+10 cycles.
- REQ-023 in_valid while not in IDLE SHALL be ignored; no input is lost when the handshake is respected.
- REQ-024 Multi-bit errors whose syndrome matches a probe SHALL be miscorrected silently; this is documented behaviour.
- REQ-025 Throughput SHALL be one word per transaction; no overlap of accept and DONE.

Reset
- REQ-026 reset low SHALL immediately force IDLE, out_valid=0, corrected=0, uncorrectable=0, out_data=0, out_crc=0, j=0, P=0, regardless of CLK or en.
- REQ-027 reset asserted mid-SEARCH or in DONE SHALL discard the word with no output.
- REQ-028 First accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
- REQ-029 Macro EDAC_ERR_CNT_EN defined SHALL add outputs corr_cnt[15:0] and fail_cnt[15:0], incremented on entry to DONE with corrected / uncorrectable, saturating at 16'hFFFF, cleared by reset.
- REQ-030 Without EDAC_ERR_CNT_EN these ports and counters SHALL be absent; all other behaviour is identical.

Verification
- REQ-031 DW=32, encode in_data=0 -> out_crc=8'h00, out_data=0, flags 0, out_valid 2 cycles after accept.
- REQ-032 DW=32, decode data=0, crc=8'h08 (j=3) -> out_data=0, out_crc=8'h00, corrected=1, latency 6.
- REQ-033 DW=8, decode data=8'h01, crc=8'h00 (j=8, S=8'h97) -> out_data=8'h00, out_crc=8'h00, corrected=1, latency 11.
- REQ-034 DW=8, decode data=0, crc=8'h03 -> out_data=8'hFF, out_crc=8'hFF, uncorrectable=1, latency 18; fail_cnt=1 with EDAC_ERR_CNT_EN.
- REQ-035 Hold out_ready=0 for 5 cycles in DONE while driving in_valid -> outputs stable, in_ready=0, then one new accept after release.
- REQ-036 Assert reset at cycle 4 of the REQ-033 search -> out_valid stays 0, FSM IDLE, next word decoded normally.

Source files
------------

// File: rtl/edac_search_pipe.sv
// edac_search_pipe: CRC-8 encoder and single-bit-error corrector over a {data, crc} codeword.
// Latency: encode/clean 2 cycles, correction at codeword bit j in j+3 cycles, uncorrectable DW+10 cycles.
// Backpressure: one word in flight; in_ready only in IDLE, results held in DONE until out_ready.
//
// Ports: CLK, reset (async active-low), en (clock enable, freezes everything when low),
//        READ/in_valid/in_ready/in_data/in_crc (input side, mode captured with the word),
//        out_valid/out_ready/out_data/out_crc/corrected/uncorrectable (result side).
// Build option: define EDAC_ERR_CNT_EN to add saturating corr_cnt / fail_cnt outputs.
module edac_search_pipe #(
  parameter int unsigned     DW         = 32,
  parameter logic [7:0]      CRC_POLY   = 8'h97,
  parameter logic [DW-1:0]   ERROR_CODE = {DW{1'b1}}
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          en,
  input  logic          READ,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [7:0]    in_crc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [7:0]    out_crc,
  output logic          corrected,
`ifdef EDAC_ERR_CNT_EN
  output logic [15:0]   corr_cnt,
  output logic [15:0]   fail_cnt,
`endif
  output logic          uncorrectable
);

  localparam int unsigned     JW     = $clog2(DW + 8);
  localparam logic [JW-1:0]   J_LAST = JW'(DW + 7);
  localparam logic [DW+7:0]   CW_ONE = {{(DW + 7){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CHECK, SEARCH, DONE} state_t;

  // Bit-serial CRC-8, MSB first, zero init, no reflection, no final XOR.
  function automatic logic [7:0] crc8(input logic [DW-1:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = DW - 1; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      syn_q, syn_d;
  logic [7:0]      p_q, p_d;
  logic [JW-1:0]   j_q, j_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [7:0]      out_crc_q, out_crc_d;
  logic            corr_q, corr_d;
  logic            unc_q, unc_d;

  logic [7:0]      enc_crc;
  logic [7:0]      syn_calc;
  logic [DW+7:0]   fixed_cw;

  assign enc_crc  = crc8(data_q);
  assign syn_calc = enc_crc ^ crc_q;
  // Candidate repair: the stored codeword with bit j inverted (bit 0 = crc[0], bit 8 = data[0]).
  assign fixed_cw = {data_q, crc_q} ^ (CW_ONE << j_q);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    data_d     = data_q;
    crc_d      = crc_q;
    syn_d      = syn_q;
    p_d        = p_q;
    j_d        = j_q;
    out_data_d = out_data_q;
    out_crc_d  = out_crc_q;
    corr_d     = corr_q;
    unc_d      = unc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          crc_d   = in_crc;
          mode_d  = READ;
          state_d = CHECK;
        end
      end
      CHECK: begin
        corr_d = 1'b0;
        unc_d  = 1'b0;
        if (!mode_q) begin
          out_data_d = data_q;
          out_crc_d  = enc_crc;
          state_d    = DONE;
        end else if (syn_calc == 8'h00) begin
          out_data_d = data_q;
          out_crc_d  = crc_q;
          state_d    = DONE;
        end else begin
          syn_d   = syn_calc;
          j_d     = '0;
          p_d     = 8'h01;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        // p_q is x^j mod g(x): the syndrome a lone error at codeword bit j would produce.
        if (p_q == syn_q) begin
          out_data_d = fixed_cw[DW+7:8];
          out_crc_d  = fixed_cw[7:0];
          corr_d     = 1'b1;
          state_d    = DONE;
        end else if (j_q == J_LAST) begin
          out_data_d = ERROR_CODE;
          out_crc_d  = 8'hFF;
          unc_d      = 1'b1;
          state_d    = DONE;
        end else begin
          j_d = j_q + JW'(1);
          p_d = {p_q[6:0], 1'b0} ^ (p_q[7] ? CRC_POLY : 8'h00);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      data_q     <= '0;
      crc_q      <= 8'h00;
      syn_q      <= 8'h00;
      p_q        <= 8'h00;
      j_q        <= '0;
      out_data_q <= '0;
      out_crc_q  <= 8'h00;
      corr_q     <= 1'b0;
      unc_q      <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      crc_q      <= crc_d;
      syn_q      <= syn_d;
      p_q        <= p_d;
      j_q        <= j_d;
      out_data_q <= out_data_d;
      out_crc_q  <= out_crc_d;
      corr_q     <= corr_d;
      unc_q      <= unc_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_data      = out_data_q;
  assign out_crc       = out_crc_q;
  assign corrected     = corr_q;
  assign uncorrectable = unc_q;

`ifdef EDAC_ERR_CNT_EN
  logic [15:0] corr_cnt_q, fail_cnt_q;
  logic        done_entry;

  assign done_entry = (state_q != DONE) && (state_d == DONE);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      corr_cnt_q <= 16'h0000;
      fail_cnt_q <= 16'h0000;
    end else if (en && done_entry) begin
      if (corr_d && (corr_cnt_q != 16'hFFFF)) corr_cnt_q <= corr_cnt_q + 16'd1;
      if (unc_d && (fail_cnt_q != 16'hFFFF))  fail_cnt_q <= fail_cnt_q + 16'd1;
    end
  end

  assign corr_cnt = corr_cnt_q;
  assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_edac_search_pipe.sv
// Scoreboard bench for edac_search_pipe (DW=32): the stimulus process pushes the expected
// result of every accepted word; a monitor process pops and compares whenever out_valid shows.
module tb_edac_search_pipe;

  localparam int DW = 32;
  localparam logic [7:0] POLY = 8'h97;

  typedef struct {
    logic [DW-1:0] d;
    logic [7:0]    c;
    logic          corr;
    logic          unc;
    int            lat;
    int            acc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          reset;
  logic          en = 1'b1;
  logic          READ;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [7:0]    in_crc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    out_crc;
  logic          corrected;
  logic          uncorrectable;
`ifdef EDAC_ERR_CNT_EN
  logic [15:0]   corr_cnt;
  logic [15:0]   fail_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  int   ecyc = 0;
  int   stall_left = 0;
  int   n_corr = 0;
  int   n_fail = 0;
  bit   en_rand = 1'b0;
  bit   rdy_rand = 1'b0;
  exp_t exp_q[$];

  edac_search_pipe #(.DW(DW), .CRC_POLY(POLY)) dut (
    .CLK(CLK),
    .reset(reset),
    .en(en),
    .READ(READ),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_crc(in_crc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_crc(out_crc),
    .corrected(corrected),
`ifdef EDAC_ERR_CNT_EN
    .corr_cnt(corr_cnt),
    .fail_cnt(fail_cnt),
`endif
    .uncorrectable(uncorrectable)
  );

  always #5 CLK = ~CLK;

  // Counts only the edges the DUT actually acts on, so latency is measured in enabled cycles.
  always @(posedge CLK) if (reset && en) ecyc <= ecyc + 1;

  initial begin : en_driver
    forever begin
      @(negedge CLK);
      en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [DW-1:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = DW - 1; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ POLY;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Reference: try every single-bit flip of the codeword in order; first one that makes the
  // codeword consistent is the repair, otherwise the word is uncorrectable.
  function automatic exp_t model(input logic rd, input logic [DW-1:0] d, input logic [7:0] c);
    exp_t e;
    logic [DW+7:0] t;
    e.d = d; e.c = c; e.corr = 1'b0; e.unc = 1'b0; e.lat = 2; e.acc = 0;
    if (!rd) begin
      e.c = crc8(d);
      return e;
    end
    if (crc8(d) == c) return e;
    for (int j = 0; j < DW + 8; j++) begin
      t = {d, c};
      t[j] = ~t[j];
      if (crc8(t[DW+7:8]) == t[7:0]) begin
        e.d = t[DW+7:8]; e.c = t[7:0]; e.corr = 1'b1; e.lat = j + 3;
        return e;
      end
    end
    e.d = '1; e.c = 8'hFF; e.unc = 1'b1; e.lat = DW + 10;
    return e;
  endfunction

  // Called and returns half a cycle away from the active edge.
  task automatic send(input logic rd, input logic [DW-1:0] d, input logic [7:0] c);
    exp_t e;
    int   guard;
    guard = 0;
    READ = rd; in_data = d; in_crc = c; in_valid = 1'b1;
    forever begin
      if (in_ready && en) begin
        e = model(rd, d, c);
        e.acc = ecyc + 1;
        exp_q.push_back(e);
        @(negedge CLK); #1;
        break;
      end
      guard++;
      if (guard > 3000) begin
        chk("accept_timeout", 64'(1), 64'(0));
        break;
      end
      @(negedge CLK); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready && !out_valid)) begin
      n++;
      if (n > 3000) begin
        chk("idle_timeout", 64'(1), 64'(0));
        break;
      end
      @(negedge CLK); #1;
    end
  endtask

  initial begin : monitor
    exp_t cur;
    bit   have;
    have = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      if (!reset) begin
        have = 1'b0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        chk("in_ready_while_busy", 64'(in_ready), 64'(0));
        if (!have) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 64'(out_valid), 64'(0));
          end else begin
            cur = exp_q.pop_front();
            have = 1'b1;
            chk("latency", 64'(ecyc - cur.acc + 1), 64'(cur.lat));
            if (cur.corr) n_corr++;
            if (cur.unc)  n_fail++;
          end
        end
        if (have) begin
          chk("out_data", 64'(out_data), 64'(cur.d));
          chk("out_crc", 64'(out_crc), 64'(cur.c));
          chk("corrected", 64'(corrected), 64'(cur.corr));
          chk("uncorrectable", 64'(uncorrectable), 64'(cur.unc));
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready && en) have = 1'b0;
      end else begin
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] d;
    logic [7:0]    c;
    logic [DW+7:0] cw;
    int            kind;

    reset = 1'b0; READ = 1'b0; in_valid = 1'b0; in_data = '0; in_crc = 8'h00;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_corrected", 64'(corrected), 64'(0));
    chk("rst_uncorrectable", 64'(uncorrectable), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_crc", 64'(out_crc), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge CLK); #1;
    reset = 1'b1;

    // Directed vectors: encode zero, repair at j=3, repair at j=8, all-small syndrome.
    send(1'b0, '0, 8'h5A);
    send(1'b1, '0, 8'h08);
    send(1'b1, 32'h0000_0001, 8'h00);
    send(1'b1, '0, 8'h03);
    send(1'b1, 32'hDEAD_BEEF, crc8(32'hDEAD_BEEF));

    // Hold the result for five cycles while the next word waits on in_valid.
    wait_idle();
    stall_left = 5;
    send(1'b0, 32'h1234_5678, 8'h00);
    send(1'b1, 32'h8765_4321, crc8(32'h8765_4321) ^ 8'h40);

    // Reset in the middle of a search: the word must vanish, the next one must decode normally.
    wait_idle();
    send(1'b1, 32'h0000_0001, 8'h00);
    repeat (4) begin @(negedge CLK); #1; end
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_corrected", 64'(corrected), 64'(0));
    chk("midrst_out_data", 64'(out_data), 64'(0));
    n_corr = 0;
    n_fail = 0;
    repeat (3) begin
      @(negedge CLK); #1;
      chk("midrst_hold_out_valid", 64'(out_valid), 64'(0));
    end
    reset = 1'b1;
    send(1'b1, 32'h0000_0001, 8'h00);
    repeat (12) begin
      @(negedge CLK); #1;
    end

    // Randomised traffic with random enable gaps and output backpressure.
    en_rand = 1'b1;
    rdy_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      d = DW'({$urandom(), $urandom()});
      c = crc8(d);
      kind = $urandom_range(0, 3);
      if (kind == 1 || kind == 2) begin
        cw = {d, c};
        cw[$urandom_range(0, DW + 7)] ^= 1'b1;
        d = cw[DW+7:8];
        c = cw[7:0];
      end else if (kind == 3) begin
        c = 8'($urandom());
      end
      send(1'($urandom_range(0, 3) != 0), d, c);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(negedge CLK); #1; end
      end
    end

    en_rand = 1'b0;
    rdy_rand = 1'b0;
    wait_idle();
    repeat (3) begin @(negedge CLK); #1; end
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
`ifdef EDAC_ERR_CNT_EN
    chk("corr_cnt", 64'(corr_cnt), 64'(n_corr));
    chk("fail_cnt", 64'(fail_cnt), 64'(n_fail));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
